row_chunk_accumulator: RTL

Downstream consumer of the matrix-A chunk memory: one row-by-vector lane. It takes successive `no_of_units`-element slices of one A row plus the matching vector slice, forms the dot product through a pipelined multiply/adder tree, and accumulates across `no_of_multiples` chunks. It toggles `I_am_ready` to request each next chunk from the memory and emits the finished row result with a one-cycle valid pulse. Four instances, one per lane, sit between the A memory / vector memory and the result collector.

---
 rtl/row_chunk_accumulator.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/row_chunk_accumulator.sv
// Purpose: one row-by-vector lane; dot product of A-row chunks with vector chunks, accumulated over N chunks.
// Latency: chunk k captured (fetch_latency+1)*k cycles after start; result pulses 4 cycles after the last capture.
// Backpressure: none inside the lane; I_am_ready toggles to request each next chunk, busy blocks new starts.
module row_chunk_accumulator #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int acc_width     = 80,
    parameter int fetch_latency = 3
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   read_preprocess,
    input  logic [31:0]                            no_of_multiples,
    input  logic [element_width*no_of_units-1:0]   memA_row_chunk,
    input  logic [element_width*no_of_units-1:0]   vector_chunk,
    output logic                                   I_am_ready,
    output logic                                   busy,
    output logic [acc_width-1:0]                   result,
    output logic                                   result_valid
);

    localparam int W   = element_width;
    localparam int U   = no_of_units;
    localparam int PW  = 2 * element_width;
    localparam int WCW = (fetch_latency < 1) ? 1 : $clog2(fetch_latency + 1);
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(fetch_latency);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WCW-1:0]      wait_cnt_q;
    logic [31:0]         chunk_cnt_q;
    logic [31:0]         n_q;
    logic                more_chunks;

    // control strobes decoded from the FSM
    logic                start_acc;
    logic                capture;
    logic                do_toggle;
    logic                finish;

    // stage 0: captured chunk buses
    logic [W*U-1:0]      a_q;
    logic [W*U-1:0]      x_q;
    logic                v0_q;
    logic                last0_q;

    // stage 1: per-element products
    logic [PW-1:0]       a_ext [U];
    logic [PW-1:0]       x_ext [U];
    logic [PW-1:0]       prod_d [U];
    logic [PW-1:0]       prod_q [U];
    logic                v1_q;
    logic                last1_q;

    // stage 2: tree sum, stage 3: accumulator
    logic [acc_width-1:0] sum_d;
    logic [acc_width-1:0] sum_q;
    logic                 v2_q;
    logic                 last2_q;
    logic [acc_width-1:0] acc_q;
    logic                 v3_q;
    logic                 last3_q;

    // a chunk counter that has not yet reached N means another chunk must be requested
    assign more_chunks = (chunk_cnt_q + 32'd1) < n_q;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic; the last chunk tags itself so DRAIN ignores earlier chunks still in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (read_preprocess) begin
                    state_d = (fetch_latency == 0) ? S_SAMPLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q <= WCW'(1)) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (more_chunks) begin
                    state_d = (fetch_latency == 0) ? S_SAMPLE : S_WAIT;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (v3_q && last3_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // output decode: strobes consumed by the datapath registers below
    always_comb begin
        start_acc = (state_q == S_IDLE) && read_preprocess;
        capture   = (state_q == S_SAMPLE);
        do_toggle = (state_q == S_SAMPLE) && more_chunks;
        finish    = (state_q == S_DRAIN) && v3_q && last3_q;
        busy      = (state_q != S_IDLE);
    end

    // row bookkeeping: latched chunk count, chunk index, fetch wait and request toggle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            chunk_cnt_q <= '0;
            n_q         <= '0;
            I_am_ready  <= 1'b0;
        end else begin
            if (start_acc || do_toggle) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (state_q == S_WAIT && wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - WCW'(1);
            end
            if (start_acc) begin
                chunk_cnt_q <= '0;
                n_q         <= (no_of_multiples == 32'd0) ? 32'd1 : no_of_multiples;
            end else if (capture) begin
                chunk_cnt_q <= chunk_cnt_q + 32'd1;
            end
            if (do_toggle) begin
                I_am_ready <= ~I_am_ready;
            end
        end
    end

    // stage 0: capture both chunk buses in the SAMPLE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            x_q     <= '0;
            v0_q    <= 1'b0;
            last0_q <= 1'b0;
        end else begin
            if (capture) begin
                a_q <= memA_row_chunk;
                x_q <= vector_chunk;
            end
            v0_q    <= capture;
            last0_q <= capture && !more_chunks;
        end
    end

    // sign-extend each element to product width; the low 2W bits of the product are the signed result
    always_comb begin
        for (int i = 0; i < U; i++) begin
            a_ext[i]  = {{W{a_q[(U-i)*W-1]}}, a_q[(U-1-i)*W +: W]};
            x_ext[i]  = {{W{x_q[(U-i)*W-1]}}, x_q[(U-1-i)*W +: W]};
            prod_d[i] = a_ext[i] * x_ext[i];
        end
    end

    // stage 1: register the products
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < U; i++) begin
                prod_q[i] <= '0;
            end
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            for (int i = 0; i < U; i++) begin
                prod_q[i] <= prod_d[i];
            end
            v1_q    <= v0_q;
            last1_q <= last0_q;
        end
    end

    // adder tree over sign-extended products
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < U; i++) begin
            sum_d = sum_d + {{(acc_width-PW){prod_q[i][PW-1]}}, prod_q[i]};
        end
    end

    // stage 2: register the chunk sum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q   <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            v2_q    <= v1_q;
            last2_q <= last1_q;
        end
    end

    // stage 3: accumulate valid chunk sums, wrapping at acc_width
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            v3_q    <= 1'b0;
            last3_q <= 1'b0;
        end else begin
            if (start_acc) begin
                acc_q <= '0;
            end else if (v2_q) begin
                acc_q <= acc_q + sum_q;
            end
            v3_q    <= v2_q;
            last3_q <= v2_q && last2_q;
        end
    end

    // publish the finished row with a single-cycle valid pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= finish;
            if (finish) begin
                result <= acc_q;
            end
        end
    end

endmodule
